// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
//
// Writeback stage sitting directly behind the multiply/divide ALU. Each ALU
// result (data, flag vector, destination register index) is accepted through a
// valid/ready handshake and buffered in a 2-entry FIFO. The FIFO head is
// presented to the register-file write port. The stage also owns the
// architectural flags register (fed back to the ALU FlagsIn) and a sticky
// arithmetic-error indicator.
//
// Parameters
//   l        data and flag width
//   NoFlags  number of defined flag bits
//            bit 0 mult overflow, bit 1 div remainder,
//            bit 2 div by zero,   bit 3 div overflow
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_reset          synchronous active-high reset
//   i_in_valid       ALU result valid
//   o_in_ready       stage can accept (decoded from registered count only)
//   i_in_r           ALU result
//   i_in_flags       ALU FlagsOut
//   i_in_rd          destination register index
//   i_flags_clear    clear flags register and sticky error
//   o_flags_reg      architectural flags, feeds ALU FlagsIn
//   o_sticky_error   overflow / divide-by-zero seen since last clear
//   o_out_valid      head entry valid
//   i_out_ready      register file consumes the head entry
//   o_out_data       head result
//   o_out_rd         head destination index
//   o_out_flags      flag snapshot stored with the head entry
//   o_retire_count   number of pops, wraps modulo 2^l
// -----------------------------------------------------------------------------
module alu_writeback #(
   parameter int l       = 16,
   parameter int NoFlags = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   // ALU side
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [l-1:0] i_in_r,
   input  logic [l-1:0] i_in_flags,
   input  logic [3:0]   i_in_rd,
   // flags control
   input  logic         i_flags_clear,
   output logic [l-1:0] o_flags_reg,
   output logic         o_sticky_error,
   // register-file side
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [l-1:0] o_out_data,
   output logic [3:0]   o_out_rd,
   output logic [l-1:0] o_out_flags,
   output logic [l-1:0] o_retire_count
);

   // Overflow (bit 0), divide-by-zero (bit 2) and divide overflow (bit 3)
   // are errors; a division remainder (bit 1) is a normal outcome.
   function automatic logic f_arith_err(input logic [l-1:0] flags);
      return flags[0] | flags[2] | flags[3];
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [l-1:0]       r_mem_data  [2];
   logic [l-1:0]       r_mem_flags [2];
   logic [3:0]         r_mem_rd    [2];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic [NoFlags-1:0] r_flags;
   logic               r_sticky;
   logic [l-1:0]       r_retire;

   // ------------------------------------------------------------------
   // Next-state wires
   // ------------------------------------------------------------------
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_push;
   logic               w_pop;
   logic               w_wr_ptr_nxt;
   logic               w_rd_ptr_nxt;
   logic [1:0]         w_count_nxt;
   logic [NoFlags-1:0] w_flags_nxt;
   logic               w_sticky_nxt;
   logic [l-1:0]       w_retire_nxt;

   // Handshake decode; both sides look only at registered count so there is
   // no combinational path from i_out_ready to o_in_ready.
   always_comb begin
      w_in_ready  = (r_count != 2'd2);
      w_out_valid = (r_count != 2'd0);
      w_push      = i_in_valid & w_in_ready;
      w_pop       = w_out_valid & i_out_ready;
   end

   // FIFO pointer and occupancy update; 1-bit pointers wrap naturally.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      if (w_push) begin
         w_wr_ptr_nxt = ~r_wr_ptr;
      end else begin
         w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
         w_rd_ptr_nxt = ~r_rd_ptr;
      end else begin
         w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         // push+pop (only possible at count 1) or idle: occupancy unchanged
         default: w_count_nxt = r_count;
      endcase
   end

   // Flags register and sticky error; a push in the same cycle as a clear
   // takes priority, so freshly produced flags are never lost.
   always_comb begin
      w_flags_nxt  = r_flags;
      w_sticky_nxt = r_sticky;
      if (w_push) begin
         w_flags_nxt = i_in_flags[NoFlags-1:0];
      end else if (i_flags_clear) begin
         w_flags_nxt = {NoFlags{1'b0}};
      end else begin
         w_flags_nxt = r_flags;
      end
      if (w_push && f_arith_err(i_in_flags)) begin
         w_sticky_nxt = 1'b1;
      end else if (i_flags_clear) begin
         w_sticky_nxt = 1'b0;
      end else begin
         w_sticky_nxt = r_sticky;
      end
   end

   // Retire counter, free-running modulo 2^l.
   always_comb begin
      w_retire_nxt = r_retire;
      if (w_pop) begin
         w_retire_nxt = r_retire + l'(1);
      end else begin
         w_retire_nxt = r_retire;
      end
   end

   // Control state registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_flags  <= {NoFlags{1'b0}};
         r_sticky <= 1'b0;
         r_retire <= {l{1'b0}};
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_flags  <= w_flags_nxt;
         r_sticky <= w_sticky_nxt;
         r_retire <= w_retire_nxt;
      end
   end

   // FIFO storage; an entry is written once at push and never touched while
   // buffered, so the stored flags remain the push-time snapshot.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 2; i++) begin
            r_mem_data[i]  <= {l{1'b0}};
            r_mem_flags[i] <= {l{1'b0}};
            r_mem_rd[i]    <= 4'd0;
         end
      end else if (w_push) begin
         r_mem_data[r_wr_ptr]  <= i_in_r;
         r_mem_flags[r_wr_ptr] <= i_in_flags;
         r_mem_rd[r_wr_ptr]    <= i_in_rd;
      end else begin
         r_mem_data[r_wr_ptr]  <= r_mem_data[r_wr_ptr];
         r_mem_flags[r_wr_ptr] <= r_mem_flags[r_wr_ptr];
         r_mem_rd[r_wr_ptr]    <= r_mem_rd[r_wr_ptr];
      end
   end

   // Outputs are pure decodes of registered state (no input-to-output path).
   always_comb begin
      o_in_ready     = w_in_ready;
      o_out_valid    = w_out_valid;
      o_out_data     = r_mem_data[r_rd_ptr];
      o_out_rd       = r_mem_rd[r_rd_ptr];
      o_out_flags    = r_mem_flags[r_rd_ptr];
      o_flags_reg    = {{(l-NoFlags){1'b0}}, r_flags};
      o_sticky_error = r_sticky;
      o_retire_count = r_retire;
   end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [15:0] i_in_r = 16'h0000;
   logic [15:0] i_in_flags = 16'h0000;
   logic [3:0]  i_in_rd = 4'd0;
   logic        i_flags_clear = 1'b0;
   logic [15:0] o_flags_reg;
   logic        o_sticky_error;
   logic        o_out_valid;
   logic        i_out_ready = 1'b0;
   logic [15:0] o_out_data;
   logic [3:0]  o_out_rd;
   logic [15:0] o_out_flags;
   logic [15:0] o_retire_count;

   int n_cmp = 0;
   int n_fail = 0;

   // scoreboard and reference model state
   logic [35:0] sb[$];
   int          m_count = 0;
   logic [15:0] m_flags = 16'h0000;
   logic        m_sticky = 1'b0;
   logic [15:0] m_retire = 16'h0000;
   logic        mon_chk = 1'b1;

   alu_writeback #(.l(16), .NoFlags(4)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_in_valid     (i_in_valid),
      .o_in_ready     (o_in_ready),
      .i_in_r         (i_in_r),
      .i_in_flags     (i_in_flags),
      .i_in_rd        (i_in_rd),
      .i_flags_clear  (i_flags_clear),
      .o_flags_reg    (o_flags_reg),
      .o_sticky_error (o_sticky_error),
      .o_out_valid    (o_out_valid),
      .i_out_ready    (i_out_ready),
      .o_out_data     (o_out_data),
      .o_out_rd       (o_out_rd),
      .o_out_flags    (o_out_flags),
      .o_retire_count (o_retire_count)
   );

   always #5 i_clk = ~i_clk;

   // Monitor: mid-cycle, compare DUT against the model, pop the scoreboard on
   // each retirement, push it on each accepted input, then advance the model.
   always @(negedge i_clk) begin
      logic        push;
      logic        pop;
      logic [35:0] exp;
      if (i_reset) begin
         sb.delete();
         m_count  = 0;
         m_flags  = 16'h0000;
         m_sticky = 1'b0;
         m_retire = 16'h0000;
      end else begin
         push = i_in_valid && (m_count != 2);
         pop  = (m_count != 0) && i_out_ready;
         if (mon_chk) begin
            n_cmp++;
            if (o_in_ready !== (m_count != 2)) begin
               n_fail++;
               $display("FAIL mon_in_ready: got %b expected %b", o_in_ready, (m_count != 2));
            end
            n_cmp++;
            if (o_out_valid !== (m_count != 0)) begin
               n_fail++;
               $display("FAIL mon_out_valid: got %b expected %b", o_out_valid, (m_count != 0));
            end
            n_cmp++;
            if ({o_flags_reg, o_sticky_error, o_retire_count} !== {m_flags, m_sticky, m_retire}) begin
               n_fail++;
               $display("FAIL mon_flags_sticky_retire: got %h/%b/%h expected %h/%b/%h",
                        o_flags_reg, o_sticky_error, o_retire_count, m_flags, m_sticky, m_retire);
            end
         end
         if (pop) begin
            exp = sb.pop_front();
            if (mon_chk) begin
               n_cmp++;
               if ({o_out_data, o_out_flags, o_out_rd} !== exp) begin
                  n_fail++;
                  $display("FAIL sb_head: got data=%h flags=%h rd=%h expected data=%h flags=%h rd=%h",
                           o_out_data, o_out_flags, o_out_rd, exp[35:20], exp[19:4], exp[3:0]);
               end
            end
            m_retire = m_retire + 16'd1;
         end
         if (push) begin
            sb.push_back({i_in_r, i_in_flags, i_in_rd});
            m_flags = {12'h000, i_in_flags[3:0]};
            if (i_in_flags[0] | i_in_flags[2] | i_in_flags[3]) begin
               m_sticky = 1'b1;
            end else if (i_flags_clear) begin
               m_sticky = 1'b0;
            end
         end else if (i_flags_clear) begin
            m_flags  = 16'h0000;
            m_sticky = 1'b0;
         end
         m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] r, input logic [15:0] f,
                        input logic [3:0] rd, input logic ordy, input logic clr);
      i_in_valid    = v;
      i_in_r        = r;
      i_in_flags    = f;
      i_in_rd       = rd;
      i_out_ready   = ordy;
      i_flags_clear = clr;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({o_in_ready, o_out_valid, o_out_data, o_out_rd, o_out_flags} !== {1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset_fifo: got rdy=%b vld=%b d=%h rd=%h f=%h expected 1 0 0000 0 0000",
                  o_in_ready, o_out_valid, o_out_data, o_out_rd, o_out_flags);
      end
      n_cmp++;
      if ({o_flags_reg, o_sticky_error, o_retire_count} !== {16'h0000, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset_regs: got %h/%b/%h expected 0000/0/0000", o_flags_reg, o_sticky_error, o_retire_count);
      end
   endtask

   task automatic test_single_push();
      drive(1'b1, 16'h0007, 16'h0002, 4'd3, 1'b1, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
      n_cmp++;
      if ({o_out_valid, o_out_data, o_out_rd, o_flags_reg, o_sticky_error} !== {1'b1, 16'h0007, 4'd3, 16'h0002, 1'b0}) begin
         n_fail++;
         $display("FAIL single_push: got vld=%b d=%h rd=%h fl=%h st=%b expected 1 0007 3 0002 0",
                  o_out_valid, o_out_data, o_out_rd, o_flags_reg, o_sticky_error);
      end
      tick();
      n_cmp++;
      if ({o_retire_count, o_out_valid} !== {16'h0001, 1'b0}) begin
         n_fail++;
         $display("FAIL single_retire: got cnt=%h vld=%b expected 0001 0", o_retire_count, o_out_valid);
      end
   endtask

   task automatic test_fill_drain();
      drive(1'b1, 16'h0011, 16'h0000, 4'd1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0022, 16'h0000, 4'd2, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({o_in_ready, o_out_valid, o_out_data} !== {1'b0, 1'b1, 16'h0011}) begin
         n_fail++;
         $display("FAIL fill_full: got rdy=%b vld=%b d=%h expected 0 1 0011", o_in_ready, o_out_valid, o_out_data);
      end
      drive(1'b1, 16'h0033, 16'h0000, 4'd3, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({o_in_ready, o_out_data} !== {1'b0, 16'h0011}) begin
         n_fail++;
         $display("FAIL fill_third_blocked: got rdy=%b d=%h expected 0 0011", o_in_ready, o_out_data);
      end
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({o_in_ready, o_out_valid, o_out_data} !== {1'b1, 1'b1, 16'h0022}) begin
         n_fail++;
         $display("FAIL drain_first: got rdy=%b vld=%b d=%h expected 1 1 0022", o_in_ready, o_out_valid, o_out_data);
      end
      tick();
      n_cmp++;
      if (o_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: got vld=%b expected 0", o_out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [15:0] v;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         v = 16'(i);
         drive(1'b1, v, 16'h0000, v[3:0], 1'b1, 1'b0);
         tick();
         n_cmp++;
         if ({o_out_valid, o_out_data, o_in_ready} !== {1'b1, v, 1'b1}) begin
            n_fail++;
            $display("FAIL stream_%0d: got vld=%b d=%h rdy=%b expected 1 %h 1", i, o_out_valid, o_out_data, o_in_ready, v);
         end
      end
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({o_retire_count, o_out_valid} !== {16'h0008, 1'b0}) begin
         n_fail++;
         $display("FAIL stream_retire: got cnt=%h vld=%b expected 0008 0", o_retire_count, o_out_valid);
      end
   endtask

   task automatic test_sticky();
      do_reset();
      drive(1'b1, 16'h0005, 16'h0004, 4'd1, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({o_sticky_error, o_flags_reg} !== {1'b1, 16'h0004}) begin
         n_fail++;
         $display("FAIL sticky_set: got st=%b fl=%h expected 1 0004", o_sticky_error, o_flags_reg);
      end
      drive(1'b1, 16'h0006, 16'h0000, 4'd2, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({o_sticky_error, o_flags_reg} !== {1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL sticky_hold: got st=%b fl=%h expected 1 0000", o_sticky_error, o_flags_reg);
      end
      drive(1'b1, 16'h0007, 16'h0002, 4'd3, 1'b1, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b1);
      tick();
      n_cmp++;
      if ({o_sticky_error, o_flags_reg} !== {1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL sticky_clear: got st=%b fl=%h expected 0 0000", o_sticky_error, o_flags_reg);
      end
      drive(1'b1, 16'h0008, 16'h0002, 4'd4, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({o_sticky_error, o_flags_reg} !== {1'b0, 16'h0002}) begin
         n_fail++;
         $display("FAIL sticky_remainder: got st=%b fl=%h expected 0 0002", o_sticky_error, o_flags_reg);
      end
      drive(1'b1, 16'h0009, 16'h0001, 4'd5, 1'b1, 1'b1);
      tick();
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
      n_cmp++;
      if ({o_sticky_error, o_flags_reg} !== {1'b1, 16'h0001}) begin
         n_fail++;
         $display("FAIL sticky_clear_push: got st=%b fl=%h expected 1 0001", o_sticky_error, o_flags_reg);
      end
      tick();
   endtask

   task automatic test_upper_bits();
      drive(1'b1, 16'h00AA, 16'hFFF0, 4'd6, 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      n_cmp++;
      if ({o_flags_reg, o_out_flags, o_sticky_error} !== {16'h0000, 16'hFFF0, 1'b1}) begin
         n_fail++;
         $display("FAIL upper_bits: got fl=%h of=%h st=%b expected 0000 fff0 1", o_flags_reg, o_out_flags, o_sticky_error);
      end
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_retire_wrap();
      do_reset();
      mon_chk = 1'b0;
      drive(1'b1, 16'h1234, 16'h0000, 4'd7, 1'b1, 1'b0);
      // 65536 accepted pushes; the first has nothing to pop alongside it
      repeat (65536) tick();
      mon_chk = 1'b1;
      n_cmp++;
      if ({o_retire_count, o_out_valid} !== {16'hFFFF, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_preload: got cnt=%h vld=%b expected ffff 1", o_retire_count, o_out_valid);
      end
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({o_retire_count, o_out_valid} !== {16'h0000, 1'b0}) begin
         n_fail++;
         $display("FAIL wrap_rollover: got cnt=%h vld=%b expected 0000 0", o_retire_count, o_out_valid);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 16'h0041, 16'h0001, 4'd8, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0042, 16'h0008, 4'd9, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({o_in_ready, o_sticky_error, o_flags_reg} !== {1'b0, 1'b1, 16'h0008}) begin
         n_fail++;
         $display("FAIL mid_prefill: got rdy=%b st=%b fl=%h expected 0 1 0008", o_in_ready, o_sticky_error, o_flags_reg);
      end
      i_reset = 1'b1;
      drive(1'b1, 16'h0099, 16'h0004, 4'd5, 1'b1, 1'b1);
      tick();
      i_reset = 1'b0;
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      n_cmp++;
      if ({o_out_valid, o_in_ready, o_flags_reg, o_sticky_error, o_retire_count, o_out_data} !==
          {1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
         n_fail++;
         $display("FAIL mid_reset: got vld=%b rdy=%b fl=%h st=%b cnt=%h d=%h expected 0 1 0000 0 0000 0000",
                  o_out_valid, o_in_ready, o_flags_reg, o_sticky_error, o_retire_count, o_out_data);
      end
      drive(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({o_out_valid, o_retire_count} !== {1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL mid_no_retained: got vld=%b cnt=%h expected 0 0000", o_out_valid, o_retire_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill_drain();
      test_streaming();
      test_sticky();
      test_upper_bits();
      test_retire_wrap();
      test_reset_mid();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
